// File: rtl/cfg_info_axi_responder_pkg.sv
// Shared types and constants for the read-only core configuration AXI responder:
// configuration struct, register word indices, feature bit positions and AXI enums.
package cfg_info_axi_responder_pkg;

    localparam int unsigned MAX_RULES = 16;

    // Elaborated core configuration as exposed to software; region tables pack rule k
    // into bits [64k+63:64k] of each vector.
    typedef struct packed {
        logic                     RVA;
        logic                     RVB;
        logic                     RVC;
        logic                     RVH;
        logic                     RVV;
        logic                     RVZCB;
        logic                     FpuEn;
        logic                     CvxifEn;
        logic                     ZiCondExtEn;
        logic                     RVS;
        logic                     RVU;
        logic                     DebugEn;
        logic [31:0]              NrCommitPorts;
        logic [31:0]              NrLoadBufEntries;
        logic [31:0]              RASDepth;
        logic [31:0]              BTBEntries;
        logic [31:0]              BHTEntries;
        logic [31:0]              NrPMPEntries;
        logic [31:0]              NrExecuteRegionRules;
        logic [31:0]              NrCachedRegionRules;
        logic [31:0]              NrNonIdempotentRules;
        logic [64*MAX_RULES-1:0]  ExecuteRegionAddrBase;
        logic [64*MAX_RULES-1:0]  ExecuteRegionLength;
        logic [64*MAX_RULES-1:0]  CachedRegionAddrBase;
        logic [64*MAX_RULES-1:0]  CachedRegionLength;
        logic [64*MAX_RULES-1:0]  NonIdempotentAddrBase;
        logic [64*MAX_RULES-1:0]  NonIdempotentLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    localparam logic [31:0] CFG_MAGIC   = 32'h4356_4136;
    localparam logic [31:0] CFG_VERSION = 32'h0001_0000;

    // Word indices (byte offset / 4) of the scalar register block
    localparam logic [7:0] IDX_MAGIC       = 8'h00;
    localparam logic [7:0] IDX_VERSION     = 8'h01;
    localparam logic [7:0] IDX_FEATURES    = 8'h02;
    localparam logic [7:0] IDX_COMMIT      = 8'h03;
    localparam logic [7:0] IDX_LOAD_BUF    = 8'h04;
    localparam logic [7:0] IDX_RAS         = 8'h05;
    localparam logic [7:0] IDX_BTB         = 8'h06;
    localparam logic [7:0] IDX_BHT         = 8'h07;
    localparam logic [7:0] IDX_PMP         = 8'h08;
    localparam logic [7:0] IDX_NR_EXEC     = 8'h09;
    localparam logic [7:0] IDX_NR_CACHED   = 8'h0A;
    localparam logic [7:0] IDX_NR_NONIDEM  = 8'h0B;

    localparam int unsigned FEATURE_RVA         = 0;
    localparam int unsigned FEATURE_RVB         = 1;
    localparam int unsigned FEATURE_RVC         = 2;
    localparam int unsigned FEATURE_RVH         = 3;
    localparam int unsigned FEATURE_RVV         = 4;
    localparam int unsigned FEATURE_RVZCB       = 5;
    localparam int unsigned FEATURE_FPU_EN      = 6;
    localparam int unsigned FEATURE_CVXIF_EN    = 7;
    localparam int unsigned FEATURE_ZICOND_EN   = 8;
    localparam int unsigned FEATURE_RVS         = 9;
    localparam int unsigned FEATURE_RVU         = 10;
    localparam int unsigned FEATURE_DEBUG_EN    = 11;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    function automatic logic [31:0] feature_word(input cva6_cfg_t cfg);
        logic [31:0] f;
        f = '0;
        f[FEATURE_RVA]       = cfg.RVA;
        f[FEATURE_RVB]       = cfg.RVB;
        f[FEATURE_RVC]       = cfg.RVC;
        f[FEATURE_RVH]       = cfg.RVH;
        f[FEATURE_RVV]       = cfg.RVV;
        f[FEATURE_RVZCB]     = cfg.RVZCB;
        f[FEATURE_FPU_EN]    = cfg.FpuEn;
        f[FEATURE_CVXIF_EN]  = cfg.CvxifEn;
        f[FEATURE_ZICOND_EN] = cfg.ZiCondExtEn;
        f[FEATURE_RVS]       = cfg.RVS;
        f[FEATURE_RVU]       = cfg.RVU;
        f[FEATURE_DEBUG_EN]  = cfg.DebugEn;
        return f;
    endfunction

endpackage

// File: rtl/cfg_info_axi_responder_if.sv
// AXI4 subset used by the configuration responder: AR/R read path plus AW/W/B write path
// (write data and strobes are not carried because the responder discards them).
interface cfg_info_axi_responder_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 4
);
    logic                 ar_valid;
    logic                 ar_ready;
    logic [AddrWidth-1:0] ar_addr;
    logic [7:0]           ar_len;
    logic [1:0]           ar_burst;
    logic [IdWidth-1:0]   ar_id;

    logic                 r_valid;
    logic                 r_ready;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;
    logic                 r_last;
    logic [IdWidth-1:0]   r_id;

    logic                 aw_valid;
    logic                 aw_ready;
    logic [IdWidth-1:0]   aw_id;

    logic                 w_valid;
    logic                 w_ready;
    logic                 w_last;

    logic                 b_valid;
    logic                 b_ready;
    logic [1:0]           b_resp;
    logic [IdWidth-1:0]   b_id;

    modport master (
        output ar_valid, ar_addr, ar_len, ar_burst, ar_id, r_ready,
               aw_valid, aw_id, w_valid, w_last, b_ready,
        input  ar_ready, r_valid, r_data, r_resp, r_last, r_id,
               aw_ready, w_ready, b_valid, b_resp, b_id
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_burst, ar_id, r_ready,
               aw_valid, aw_id, w_valid, w_last, b_ready,
        output ar_ready, r_valid, r_data, r_resp, r_last, r_id,
               aw_ready, w_ready, b_valid, b_resp, b_id
    );
endinterface

// File: rtl/cfg_info_axi_responder_decode.sv
// Combinational config-word lookup: 8-bit word index -> data word and AXI response.
// Pure function of the elaborated configuration.
module cfg_info_axi_responder_decode
    import cfg_info_axi_responder_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
    input  logic [7:0]  word_idx,
    output logic [31:0] data,
    output axi_resp_e   resp
);
    // Table 0 = execute, 1 = cached, 2 = non-idempotent
    logic [63:0] rule_base  [3][MAX_RULES];
    logic [63:0] rule_len   [3][MAX_RULES];
    logic [31:0] rule_count [3];

    for (genvar gi = 0; gi < MAX_RULES; gi++) begin : g_rule
        assign rule_base[0][gi] = CVA6Cfg.ExecuteRegionAddrBase[64*gi +: 64];
        assign rule_len[0][gi]  = CVA6Cfg.ExecuteRegionLength[64*gi +: 64];
        assign rule_base[1][gi] = CVA6Cfg.CachedRegionAddrBase[64*gi +: 64];
        assign rule_len[1][gi]  = CVA6Cfg.CachedRegionLength[64*gi +: 64];
        assign rule_base[2][gi] = CVA6Cfg.NonIdempotentAddrBase[64*gi +: 64];
        assign rule_len[2][gi]  = CVA6Cfg.NonIdempotentLength[64*gi +: 64];
    end

    assign rule_count[0] = CVA6Cfg.NrExecuteRegionRules;
    assign rule_count[1] = CVA6Cfg.NrCachedRegionRules;
    assign rule_count[2] = CVA6Cfg.NrNonIdempotentRules;

    // word_idx[7:6] selects register block vs table, [5:2] the entry, [1:0] the word
    logic [1:0] tbl_sel;
    logic [3:0] entry;
    logic [1:0] word_sel;

    assign tbl_sel  = word_idx[7:6] - 2'd1;
    assign entry    = word_idx[5:2];
    assign word_sel = word_idx[1:0];

    always_comb begin
        data = '0;
        resp = RESP_OKAY;
        if (word_idx[7:6] == 2'd0) begin
            case (word_idx)
                IDX_MAGIC:      data = CFG_MAGIC;
                IDX_VERSION:    data = CFG_VERSION;
                IDX_FEATURES:   data = feature_word(CVA6Cfg);
                IDX_COMMIT:     data = CVA6Cfg.NrCommitPorts;
                IDX_LOAD_BUF:   data = CVA6Cfg.NrLoadBufEntries;
                IDX_RAS:        data = CVA6Cfg.RASDepth;
                IDX_BTB:        data = CVA6Cfg.BTBEntries;
                IDX_BHT:        data = CVA6Cfg.BHTEntries;
                IDX_PMP:        data = CVA6Cfg.NrPMPEntries;
                IDX_NR_EXEC:    data = CVA6Cfg.NrExecuteRegionRules;
                IDX_NR_CACHED:  data = CVA6Cfg.NrCachedRegionRules;
                IDX_NR_NONIDEM: data = CVA6Cfg.NrNonIdempotentRules;
                default:        resp = RESP_DECERR;
            endcase
        end else if ({28'd0, entry} < rule_count[tbl_sel]) begin
            case (word_sel)
                2'd0:    data = rule_base[tbl_sel][entry][31:0];
                2'd1:    data = rule_base[tbl_sel][entry][63:32];
                2'd2:    data = rule_len[tbl_sel][entry][31:0];
                default: data = rule_len[tbl_sel][entry][63:32];
            endcase
        end
    end

endmodule

// File: rtl/cfg_info_axi_responder.sv
// Read-only AXI4 slave exposing the elaborated core configuration as constant words.
// Reads are decoded per beat; writes are drained and answered SLVERR.
module cfg_info_axi_responder
    import cfg_info_axi_responder_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg   = cva6_cfg_empty,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    cfg_info_axi_responder_if.slave  bus
);
    // Held low during reset and for the reset-release edge so the ready outputs stay 0
    logic rst_done_reg;

    rd_state_e          rd_state_reg, rd_state_next;
    logic [IdWidth-1:0] r_id_reg;
    logic [7:0]         word_idx_reg;
    logic [7:0]         len_reg;
    logic [7:0]         cnt_reg;
    axi_burst_e         burst_reg;
    logic               hi_err_reg;

    wr_state_e          wr_state_reg, wr_state_next;
    logic [IdWidth-1:0] aw_id_reg;

    logic               ar_hs, r_hs, aw_hs, w_hs, b_hs, last_beat;
    logic [31:0]        dec_data;
    axi_resp_e          dec_resp;
    logic [DataWidth-1:0] beat_data;
    axi_resp_e          beat_resp;
    logic               unused_addr_bits;

    assign ar_hs     = bus.ar_valid && bus.ar_ready;
    assign r_hs      = bus.r_valid && bus.r_ready;
    assign aw_hs     = bus.aw_valid && bus.aw_ready;
    assign w_hs      = bus.w_valid && bus.w_ready;
    assign b_hs      = bus.b_valid && bus.b_ready;
    assign last_beat = (cnt_reg == len_reg);
    assign unused_addr_bits = ^bus.ar_addr[1:0];

    cfg_info_axi_responder_decode #(
        .CVA6Cfg (CVA6Cfg)
    ) u_decode (
        .word_idx (word_idx_reg),
        .data     (dec_data),
        .resp     (dec_resp)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_done_reg <= 1'b0;
            rd_state_reg <= R_IDLE;
            wr_state_reg <= W_IDLE;
        end else begin
            rst_done_reg <= 1'b1;
            rd_state_reg <= rd_state_next;
            wr_state_reg <= wr_state_next;
        end
    end

    // Read burst bookkeeping; address stays put for FIXED and advances mod 256 for INCR
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id_reg     <= '0;
            word_idx_reg <= '0;
            len_reg      <= '0;
            cnt_reg      <= '0;
            burst_reg    <= BURST_FIXED;
            hi_err_reg   <= 1'b0;
        end else if (ar_hs) begin
            r_id_reg     <= bus.ar_id;
            word_idx_reg <= bus.ar_addr[9:2];
            len_reg      <= bus.ar_len;
            cnt_reg      <= '0;
            burst_reg    <= axi_burst_e'(bus.ar_burst);
            hi_err_reg   <= |bus.ar_addr[AddrWidth-1:10];
        end else if (r_hs && !last_beat) begin
            cnt_reg <= cnt_reg + 8'd1;
            if (burst_reg == BURST_INCR) begin
                word_idx_reg <= word_idx_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_id_reg <= '0;
        end else if (aw_hs) begin
            aw_id_reg <= bus.aw_id;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
            R_DATA:  if (r_hs && last_beat) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE:  if (aw_hs) wr_state_next = W_DATA;
            W_DATA:  if (w_hs && bus.w_last) wr_state_next = W_RESP;
            W_RESP:  if (b_hs) wr_state_next = W_IDLE;
            default: wr_state_next = W_IDLE;
        endcase
    end

    // WRAP (and the reserved encoding) is refused per beat; high address bits mean no slave
    always_comb begin
        beat_data = DataWidth'(dec_data);
        beat_resp = dec_resp;
        if (burst_reg == BURST_WRAP || burst_reg == BURST_RSVD) begin
            beat_data = '0;
            beat_resp = RESP_SLVERR;
        end else if (hi_err_reg) begin
            beat_data = '0;
            beat_resp = RESP_DECERR;
        end
    end

    always_comb begin
        bus.ar_ready = 1'b0;
        bus.r_valid  = 1'b0;
        bus.r_data   = '0;
        bus.r_resp   = RESP_OKAY;
        bus.r_last   = 1'b0;
        bus.r_id     = '0;
        case (rd_state_reg)
            R_IDLE: bus.ar_ready = rst_done_reg;
            R_DATA: begin
                bus.r_valid = 1'b1;
                bus.r_data  = beat_data;
                bus.r_resp  = beat_resp;
                bus.r_last  = last_beat;
                bus.r_id    = r_id_reg;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b0;
        bus.b_valid  = 1'b0;
        bus.b_resp   = RESP_OKAY;
        bus.b_id     = '0;
        case (wr_state_reg)
            W_IDLE: bus.aw_ready = rst_done_reg;
            W_DATA: bus.w_ready  = 1'b1;
            W_RESP: begin
                bus.b_valid = 1'b1;
                bus.b_resp  = RESP_SLVERR;
                bus.b_id    = aw_id_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cfg_info_axi_responder.sv
// Self-checking bench for cfg_info_axi_responder: directed scenarios plus random bursts
// compared against a byte-offset based model of the configuration map.
module tb_cfg_info_axi_responder;
    import cfg_info_axi_responder_pkg::*;

    localparam cva6_cfg_t TB_CFG = '{
        RVA: 1'b1, RVB: 1'b0, RVC: 1'b1, RVH: 1'b0, RVV: 1'b0, RVZCB: 1'b0,
        FpuEn: 1'b0, CvxifEn: 1'b0, ZiCondExtEn: 1'b0, RVS: 1'b1, RVU: 1'b1, DebugEn: 1'b1,
        NrCommitPorts: 32'd1, NrLoadBufEntries: 32'd2, RASDepth: 32'd2,
        BTBEntries: 32'd32, BHTEntries: 32'd128, NrPMPEntries: 32'd8,
        NrExecuteRegionRules: 32'd3, NrCachedRegionRules: 32'd1, NrNonIdempotentRules: 32'd2,
        ExecuteRegionAddrBase: {832'h0, 64'h8000_0000, 64'h1_0000, 64'h0},
        ExecuteRegionLength:   {832'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
        CachedRegionAddrBase:  {960'h0, 64'h8000_0000},
        CachedRegionLength:    {960'h0, 64'h4000_0000},
        NonIdempotentAddrBase: {896'h0, 64'h12_3456_7000, 64'h0},
        NonIdempotentLength:   {896'h0, 64'h1_0000_0000, 64'h8000_0000}
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [31:0] q_data[$];
    logic [1:0]  q_resp[$];
    logic        q_last[$];
    logic [3:0]  q_id[$];

    cfg_info_axi_responder_if #(.AddrWidth(64), .DataWidth(32), .IdWidth(4)) bus ();

    cfg_info_axi_responder #(
        .CVA6Cfg   (TB_CFG),
        .AddrWidth (64),
        .DataWidth (32),
        .IdWidth   (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {resp, data} for one byte address, straight from the documented map
    function automatic logic [33:0] model_word(input logic [63:0] addr);
        int unsigned off, t, k, w, cnt;
        logic [63:0] base, len, v;
        off = {22'd0, addr[9:2], 2'b00};
        if (addr[63:10] != 54'd0) return {2'b11, 32'h0};
        case (off)
            'h000: return {2'b00, 32'h4356_4136};
            'h004: return {2'b00, 32'h0001_0000};
            'h008: return {2'b00, 20'h0, TB_CFG.DebugEn, TB_CFG.RVU, TB_CFG.RVS, TB_CFG.ZiCondExtEn,
                           TB_CFG.CvxifEn, TB_CFG.FpuEn, TB_CFG.RVZCB, TB_CFG.RVV, TB_CFG.RVH,
                           TB_CFG.RVC, TB_CFG.RVB, TB_CFG.RVA};
            'h00C: return {2'b00, TB_CFG.NrCommitPorts};
            'h010: return {2'b00, TB_CFG.NrLoadBufEntries};
            'h014: return {2'b00, TB_CFG.RASDepth};
            'h018: return {2'b00, TB_CFG.BTBEntries};
            'h01C: return {2'b00, TB_CFG.BHTEntries};
            'h020: return {2'b00, TB_CFG.NrPMPEntries};
            'h024: return {2'b00, TB_CFG.NrExecuteRegionRules};
            'h028: return {2'b00, TB_CFG.NrCachedRegionRules};
            'h02C: return {2'b00, TB_CFG.NrNonIdempotentRules};
            default: ;
        endcase
        if (off < 'h100) return {2'b11, 32'h0};
        t = off / 256;
        k = (off % 256) / 16;
        w = (off % 16) / 4;
        if (t == 1) begin
            cnt = TB_CFG.NrExecuteRegionRules;
            base = TB_CFG.ExecuteRegionAddrBase[64*k +: 64];
            len = TB_CFG.ExecuteRegionLength[64*k +: 64];
        end else if (t == 2) begin
            cnt = TB_CFG.NrCachedRegionRules;
            base = TB_CFG.CachedRegionAddrBase[64*k +: 64];
            len = TB_CFG.CachedRegionLength[64*k +: 64];
        end else begin
            cnt = TB_CFG.NrNonIdempotentRules;
            base = TB_CFG.NonIdempotentAddrBase[64*k +: 64];
            len = TB_CFG.NonIdempotentLength[64*k +: 64];
        end
        if (k >= cnt) return {2'b00, 32'h0};
        v = (w < 2) ? base : len;
        return {2'b00, (w % 2 == 1) ? v[63:32] : v[31:0]};
    endfunction

    function automatic logic [33:0] exp_beat(input logic [63:0] addr, input logic [1:0] burst,
                                             input int i);
        logic [63:0] a;
        if (burst == 2'b10) return {2'b10, 32'h0};
        a = addr;
        if (burst == 2'b01) a[9:2] = addr[9:2] + 8'(i);
        return model_word(a);
    endfunction

    // Drives one read burst and records the returned beats (no checking here)
    task automatic run_read(input logic [63:0] addr, input int len, input logic [1:0] burst,
                            input logic [3:0] id, input int ready_pct,
                            output int timed_out, output int lat, output int ar_cyc);
        int n, beats;
        q_data.delete(); q_resp.delete(); q_last.delete(); q_id.delete();
        timed_out = 0; lat = -1; ar_cyc = -1;
        @(negedge clk);
        bus.ar_valid = 1'b1; bus.ar_addr = addr; bus.ar_len = 8'(len);
        bus.ar_burst = burst; bus.ar_id = id;
        n = 0;
        while (!bus.ar_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.ar_ready) begin bus.ar_valid = 1'b0; timed_out = 1; return; end
        ar_cyc = cyc;
        @(negedge clk);
        bus.ar_valid = 1'b0;
        beats = 0; n = 0;
        while (beats < len + 1 && n < 2000) begin
            bus.r_ready = ($urandom_range(0, 99) < ready_pct);
            if (bus.r_valid && bus.r_ready) begin
                if (beats == 0) lat = n;
                q_data.push_back(bus.r_data); q_resp.push_back(bus.r_resp);
                q_last.push_back(bus.r_last); q_id.push_back(bus.r_id);
                beats++;
            end
            @(negedge clk); n++;
        end
        bus.r_ready = 1'b0;
        timed_out = (beats < len + 1) ? 1 : 0;
    endtask

    task automatic run_write(input logic [3:0] id, input int nbeats, output logic [1:0] b_resp,
                             output logic [3:0] b_id, output logic early, output int aw_cyc,
                             output int timed_out);
        int n, i;
        timed_out = 0; b_resp = 2'b00; b_id = 4'h0; aw_cyc = -1;
        @(negedge clk);
        bus.aw_valid = 1'b1; bus.aw_id = id;
        early = bus.w_ready;
        n = 0;
        while (!bus.aw_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.aw_ready) begin bus.aw_valid = 1'b0; timed_out = 1; return; end
        aw_cyc = cyc;
        @(negedge clk);
        bus.aw_valid = 1'b0;
        i = 0; n = 0;
        bus.w_valid = 1'b1; bus.w_last = (nbeats == 1);
        while (i < nbeats && n < 200) begin
            if (bus.w_ready) i++;
            @(negedge clk); n++;
            bus.w_last = (i == nbeats - 1);
        end
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        n = 0;
        while (!bus.b_valid && n < 100) begin @(negedge clk); n++; end
        if (!bus.b_valid) begin timed_out = 1; return; end
        b_resp = bus.b_resp; b_id = bus.b_id;
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.ar_ready !== 1'b0 || bus.aw_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready ar=%b aw=%b required 0 0", bus.ar_ready, bus.aw_ready); end
        checks++; if (bus.r_valid !== 1'b0 || bus.b_valid !== 1'b0 || bus.w_ready !== 1'b0 ||
                      bus.r_data !== 32'h0) begin errors++;
            $display("FAIL reset_outputs r_valid=%b b_valid=%b w_ready=%b r_data=%h required all 0",
                     bus.r_valid, bus.b_valid, bus.w_ready, bus.r_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.ar_ready !== 1'b1 || bus.aw_ready !== 1'b1) begin errors++;
            $display("FAIL reset_release ar=%b aw=%b required 1 1", bus.ar_ready, bus.aw_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single_reads();
        int to, lat, ac;
        run_read(64'h000, 0, 2'b01, 4'd5, 100, to, lat, ac);
        checks++; if (to != 0 || lat != 0) begin errors++;
            $display("FAIL magic_latency timeout=%0d latency=%0d required 0 0", to, lat); end
        if (to == 0) begin
            checks++; if (q_data[0] !== 32'h4356_4136 || q_resp[0] !== 2'b00 || q_last[0] !== 1'b1 ||
                          q_id[0] !== 4'd5) begin errors++;
                $display("FAIL magic data=%h resp=%b last=%b id=%0d required 43564136 00 1 5",
                         q_data[0], q_resp[0], q_last[0], q_id[0]); end
        end
        checks++; if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b1) begin errors++;
            $display("FAIL after_single r_valid=%b ar_ready=%b required 0 1", bus.r_valid, bus.ar_ready); end
        run_read(64'h008, 0, 2'b00, 4'd1, 100, to, lat, ac);
        checks++; if (to != 0 || q_data[0] !== 32'h0000_0E05 || q_resp[0] !== 2'b00) begin errors++;
            $display("FAIL features data=%h resp=%b required 00000e05 00", q_data[0], q_resp[0]); end
        $display("test_single_reads done");
    endtask

    task automatic test_table_burst();
        int to, lat, ac;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h8000_0000; exp_d[1] = 32'h0; exp_d[2] = 32'h4000_0000; exp_d[3] = 32'h0;
        run_read(64'h120, 3, 2'b01, 4'd7, 100, to, lat, ac);
        checks++; if (to != 0 || q_data.size() != 4) begin errors++;
            $display("FAIL exec_burst_len timeout=%0d beats=%0d required 0 4", to, q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== exp_d[i] || q_resp[i] !== 2'b00 || q_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL exec_burst beat %0d data=%h resp=%b last=%b required %h 00 %b",
                         i, q_data[i], q_resp[i], q_last[i], exp_d[i], i == 3); end
        end
        run_read(64'h130, 0, 2'b01, 4'd0, 100, to, lat, ac);
        checks++; if (to != 0 || q_data[0] !== 32'h0 || q_resp[0] !== 2'b00) begin errors++;
            $display("FAIL unused_entry data=%h resp=%b required 0 00", q_data[0], q_resp[0]); end
        run_read(64'h040, 0, 2'b01, 4'd0, 100, to, lat, ac);
        checks++; if (to != 0 || q_data[0] !== 32'h0 || q_resp[0] !== 2'b11) begin errors++;
            $display("FAIL hole_decerr data=%h resp=%b required 0 11", q_data[0], q_resp[0]); end
        run_read(64'h400, 0, 2'b01, 4'd0, 100, to, lat, ac);
        checks++; if (to != 0 || q_data[0] !== 32'h0 || q_resp[0] !== 2'b11) begin errors++;
            $display("FAIL high_addr data=%h resp=%b required 0 11", q_data[0], q_resp[0]); end
        $display("test_table_burst done");
    endtask

    task automatic test_backpressure();
        logic [31:0] hold_d;
        logic        hold_l;
        logic [33:0] e;
        int n, beats;
        @(negedge clk);
        bus.ar_valid = 1'b1; bus.ar_addr = 64'h104; bus.ar_len = 8'd3;
        bus.ar_burst = 2'b01; bus.ar_id = 4'd2;
        n = 0;
        while (!bus.ar_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.ar_valid = 1'b0;
        bus.r_ready = 1'b1;
        @(negedge clk);
        bus.r_ready = 1'b0;
        hold_d = bus.r_data; hold_l = bus.r_last;
        checks++; if (bus.r_valid !== 1'b1 || hold_d !== 32'h0000_1000) begin errors++;
            $display("FAIL stall_beat1 r_valid=%b data=%h required 1 00001000", bus.r_valid, hold_d); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.r_valid !== 1'b1 || bus.r_data !== hold_d || bus.r_last !== hold_l ||
                          bus.ar_ready !== 1'b0) begin errors++;
                $display("FAIL stall_hold cycle %0d valid=%b data=%h last=%b ar_ready=%b required 1 %h %b 0",
                         i, bus.r_valid, bus.r_data, bus.r_last, bus.ar_ready, hold_d, hold_l); end
        end
        bus.r_ready = 1'b1;
        beats = 1; n = 0;
        while (beats < 4 && n < 50) begin
            if (bus.r_valid) begin
                e = exp_beat(64'h104, 2'b01, beats);
                checks++; if (bus.r_data !== e[31:0] || bus.r_resp !== e[33:32] ||
                              bus.r_last !== (beats == 3)) begin errors++;
                    $display("FAIL stall_resume beat %0d data=%h resp=%b last=%b required %h %b %b",
                             beats, bus.r_data, bus.r_resp, bus.r_last, e[31:0], e[33:32], beats == 3); end
                beats++;
            end
            @(negedge clk); n++;
        end
        bus.r_ready = 1'b0;
        checks++; if (beats != 4 || bus.r_valid !== 1'b0) begin errors++;
            $display("FAIL stall_end beats=%0d r_valid=%b required 4 0", beats, bus.r_valid); end
        $display("test_backpressure done");
    endtask

    task automatic test_write();
        logic [1:0] br; logic [3:0] bid; logic early; int ac, to, lat, rc;
        run_write(4'd3, 2, br, bid, early, ac, to);
        checks++; if (to != 0 || early !== 1'b0) begin errors++;
            $display("FAIL write_wready timeout=%0d early_w_ready=%b required 0 0", to, early); end
        checks++; if (br !== 2'b10 || bid !== 4'd3) begin errors++;
            $display("FAIL write_bresp resp=%b id=%0d required 10 3", br, bid); end
        checks++; if (bus.b_valid !== 1'b0 || bus.aw_ready !== 1'b1) begin errors++;
            $display("FAIL write_end b_valid=%b aw_ready=%b required 0 1", bus.b_valid, bus.aw_ready); end
        run_read(64'h000, 0, 2'b01, 4'd9, 100, to, lat, rc);
        checks++; if (to != 0 || q_data[0] !== 32'h4356_4136) begin errors++;
            $display("FAIL write_no_effect data=%h required 43564136", q_data[0]); end
        $display("test_write done");
    endtask

    task automatic test_simultaneous();
        logic [1:0] br; logic [3:0] bid; logic early;
        int aw_c, wto, rto, lat, ar_c;
        logic [33:0] e;
        fork
            run_read(64'h300, 7, 2'b01, 4'd12, 70, rto, lat, ar_c);
            run_write(4'd6, 3, br, bid, early, aw_c, wto);
        join
        checks++; if (rto != 0 || wto != 0 || ar_c != aw_c) begin errors++;
            $display("FAIL simul_accept rto=%0d wto=%0d ar_cycle=%0d aw_cycle=%0d required 0 0 equal",
                     rto, wto, ar_c, aw_c); end
        checks++; if (br !== 2'b10 || bid !== 4'd6) begin errors++;
            $display("FAIL simul_b resp=%b id=%0d required 10 6", br, bid); end
        for (int i = 0; i < q_data.size(); i++) begin
            e = exp_beat(64'h300, 2'b01, i);
            checks++; if (q_data[i] !== e[31:0] || q_resp[i] !== e[33:32] || q_id[i] !== 4'd12 ||
                          q_last[i] !== (i == 7)) begin errors++;
                $display("FAIL simul_r beat %0d data=%h resp=%b id=%0d last=%b required %h %b 12 %b",
                         i, q_data[i], q_resp[i], q_id[i], q_last[i], e[31:0], e[33:32], i == 7); end
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_midburst();
        int n, beats, to, lat, ac;
        @(negedge clk);
        bus.ar_valid = 1'b1; bus.ar_addr = 64'h000; bus.ar_len = 8'd3;
        bus.ar_burst = 2'b01; bus.ar_id = 4'd4;
        n = 0;
        while (!bus.ar_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.ar_valid = 1'b0;
        bus.r_ready = 1'b1;
        beats = 0; n = 0;
        while (beats < 2 && n < 50) begin
            if (bus.r_valid) beats++;
            @(negedge clk); n++;
        end
        bus.r_ready = 1'b0;
        checks++; if (bus.r_valid !== 1'b1 || bus.r_data !== 32'h0000_0E05) begin errors++;
            $display("FAIL pre_reset_beat2 valid=%b data=%h required 1 00000e05", bus.r_valid, bus.r_data); end
        rst = 1'b1;
        #1;
        checks++; if (bus.r_valid !== 1'b0 || bus.ar_ready !== 1'b0 || bus.r_data !== 32'h0) begin errors++;
            $display("FAIL async_reset r_valid=%b ar_ready=%b r_data=%h required 0 0 0",
                     bus.r_valid, bus.ar_ready, bus.r_data); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.ar_ready !== 1'b0) begin errors++;
            $display("FAIL release_same_cycle ar_ready=%b required 0", bus.ar_ready); end
        @(negedge clk);
        checks++; if (bus.ar_ready !== 1'b1) begin errors++;
            $display("FAIL release_next_cycle ar_ready=%b required 1", bus.ar_ready); end
        run_read(64'h004, 0, 2'b01, 4'd8, 100, to, lat, ac);
        checks++; if (to != 0 || q_data[0] !== 32'h0001_0000 || q_id[0] !== 4'd8) begin errors++;
            $display("FAIL post_reset_read data=%h id=%0d required 00010000 8", q_data[0], q_id[0]); end
        $display("test_reset_midburst done");
    endtask

    task automatic test_random();
        logic [63:0] addr; logic [1:0] burst; logic [3:0] id; int len, to, lat, ac, bad;
        logic [33:0] e;
        for (int t = 0; t < 40; t++) begin
            addr = {54'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) addr[10 + $urandom_range(0, 53)] = 1'b1;
            len   = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 7);
            burst = 2'($urandom_range(0, 2));
            id    = 4'($urandom_range(0, 15));
            run_read(addr, len, burst, id, 60, to, lat, ac);
            checks++; if (to != 0 || q_data.size() != len + 1) begin errors++;
                $display("FAIL rand_count txn %0d timeout=%0d beats=%0d required 0 %0d",
                         t, to, q_data.size(), len + 1); end
            bad = 0;
            for (int i = 0; i < q_data.size(); i++) begin
                e = exp_beat(addr, burst, i);
                checks++; if (q_data[i] !== e[31:0] || q_resp[i] !== e[33:32] || q_id[i] !== id ||
                              q_last[i] !== (i == len)) begin errors++; bad++;
                    $display("FAIL rand_beat txn %0d addr=%h burst=%0d beat %0d data=%h resp=%b id=%0d last=%b required %h %b %0d %b",
                             t, addr, burst, i, q_data[i], q_resp[i], q_id[i], q_last[i],
                             e[31:0], e[33:32], id, i == len); end
            end
            $display("rand txn %0d addr=%h len=%0d burst=%0d id=%0d beats=%0d bad=%0d",
                     t, addr, len, burst, id, q_data.size(), bad);
        end
    endtask

    initial begin
        bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_burst = '0; bus.ar_id = '0;
        bus.r_ready = 1'b0; bus.aw_valid = 1'b0; bus.aw_id = '0;
        bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.b_ready = 1'b0;
        test_reset();
        test_single_reads();
        test_table_burst();
        test_backpressure();
        test_write();
        test_simultaneous();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
